// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-set sequencer and the display scanner.
package clock_pkg;

  // Width of the mode code seen by the display scanner.
  localparam int MODE_W = 2;

  // State / mode codes (11 is unused).
  localparam logic [MODE_W-1:0] ST_RUN      = 2'b00;
  localparam logic [MODE_W-1:0] ST_SET_HOUR = 2'b01;
  localparam logic [MODE_W-1:0] ST_SET_MIN  = 2'b10;

  typedef enum logic [MODE_W-1:0] {
    S_RUN      = ST_RUN,
    S_SET_HOUR = ST_SET_HOUR,
    S_SET_MIN  = ST_SET_MIN
  } state_e;

  // True in either of the two time-setting states.
  function automatic logic is_set_state(state_e s);
    return (s == S_SET_HOUR) || (s == S_SET_MIN);
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, stability debounce,
// rising-edge press pulse and optional auto-repeat while held.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 2000000   // expected <= REPEAT_DELAY
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            rise;
  logic            repeat_fire;
  logic            press_q;

  // Debounce: count while the synchronised level differs from the accepted
  // level, accept it once it has stayed different for DEBOUNCE_CYCLES.
  always_comb begin
    // NOTE: every next-state value gets a default first, so no latch is inferred.
    level_d  = level_q;
    db_cnt_d = '0;
    rise     = 1'b0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = sync2_q;
        rise    = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  generate
    if (REPEAT_EN) begin : g_repeat
      localparam int                HOLD_W     = $clog2(REPEAT_DELAY + 1);
      localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
      localparam logic [HOLD_W-1:0] PER_LAST   = HOLD_W'(REPEAT_PERIOD - 1);

      logic [HOLD_W-1:0] hold_q, hold_d;
      logic              rep_phase_q, rep_phase_d;
      logic              fire;

      // Hold timer: first repeat after REPEAT_DELAY, then every REPEAT_PERIOD;
      // cleared whenever the debounced level is low.
      always_comb begin
        hold_d      = '0;
        rep_phase_d = 1'b0;
        fire        = 1'b0;
        if (level_q) begin
          rep_phase_d = rep_phase_q;
          if (hold_q == (rep_phase_q ? PER_LAST : DELAY_LAST)) begin
            fire        = 1'b1;
            rep_phase_d = 1'b1;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end

      // Hold timer registers.
      always_ff @(posedge clk) begin
        if (reset) begin
          hold_q      <= '0;
          rep_phase_q <= 1'b0;
        end else begin
          hold_q      <= hold_d;
          rep_phase_q <= rep_phase_d;
        end
      end

      assign repeat_fire = fire;
    end else begin : g_no_repeat
      assign repeat_fire = 1'b0;
    end
  endgenerate

  // Synchroniser, debounce state and the registered press pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is only ever written with non-blocking <=.
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= rise | repeat_fire;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/clock_set_controller.sv
// Time-set sequencer: RUN / SET_HOUR / SET_MIN mode FSM, set-mode timeout,
// blink phase and registered control pulses for the 12-hour clock core.
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 2000000,
  parameter int TIMEOUT_HALF    = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              tick_half,
  output logic              run_en,
  output logic              inc_hour,
  output logic              inc_min,
  output logic              clr_sec,
  output logic              blank_hour,
  output logic              blank_min,
  output logic [MODE_W-1:0] mode
);

  localparam int               TMO_W    = $clog2(TIMEOUT_HALF + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_HALF - 1);

  logic mode_press_raw, inc_press_raw;
  logic mode_press, inc_press;
  logic timeout_hit;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             blink_q, blink_d;
  logic             run_en_q, run_en_d;
  logic             inc_hour_q, inc_hour_d;
  logic             inc_min_q, inc_min_d;
  logic             clr_sec_q, clr_sec_d;
  logic             blank_hour_q, blank_hour_d;
  logic             blank_min_q, blank_min_d;

  button_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_EN       (1'b0),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_mode_btn (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_mode),
    .press_o (mode_press_raw)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_EN       (1'b1),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_inc_btn (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_inc),
    .press_o (inc_press_raw)
  );

  // Presses while disabled are discarded; MODE wins over a same-cycle INC.
  assign mode_press  = mode_press_raw & en;
  assign inc_press   = inc_press_raw & en & ~mode_press;
  // A press in the same cycle cancels the timeout.
  assign timeout_hit = is_set_state(state_q) && tick_half && (tmo_q == TMO_LAST)
                       && !mode_press && !inc_press;

  // Next state, timeout count, blink phase and pulse requests.
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    blink_d    = blink_q;
    inc_hour_d = 1'b0;
    inc_min_d  = 1'b0;
    clr_sec_d  = 1'b0;

    if (en) begin
      unique case (state_q)
        S_RUN: begin
          if (mode_press) state_d = S_SET_HOUR;
        end
        S_SET_HOUR: begin
          if (mode_press) begin
            state_d = S_SET_MIN;
          end else if (inc_press) begin
            inc_hour_d = 1'b1;
          end else if (timeout_hit) begin
            state_d   = S_RUN;
            clr_sec_d = 1'b1;
          end
        end
        S_SET_MIN: begin
          if (mode_press || timeout_hit) begin
            state_d   = S_RUN;
            clr_sec_d = 1'b1;
          end else if (inc_press) begin
            inc_min_d = 1'b1;
          end
        end
        default: state_d = S_RUN;
      endcase

      // Timeout count never passes TMO_LAST: the tick that would reach
      // TIMEOUT_HALF leaves the SET state and the count restarts at 0.
      if ((state_d != state_q) || !is_set_state(state_q) || mode_press || inc_press) begin
        tmo_d = '0;
      end else if (tick_half) begin
        tmo_d = tmo_q + TMO_W'(1);
      end

      if (state_d != state_q) begin
        blink_d = 1'b0;
      end else if (is_set_state(state_q) && tick_half) begin
        blink_d = ~blink_q;
      end
    end

    run_en_d     = en && (state_d == S_RUN);
    blank_hour_d = (state_d == S_SET_HOUR) && blink_d;
    blank_min_d  = (state_d == S_SET_MIN) && blink_d;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_RUN;
      tmo_q        <= '0;
      blink_q      <= 1'b0;
      run_en_q     <= 1'b1;
      inc_hour_q   <= 1'b0;
      inc_min_q    <= 1'b0;
      clr_sec_q    <= 1'b0;
      blank_hour_q <= 1'b0;
      blank_min_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      blink_q      <= blink_d;
      run_en_q     <= run_en_d;
      inc_hour_q   <= inc_hour_d;
      inc_min_q    <= inc_min_d;
      clr_sec_q    <= clr_sec_d;
      blank_hour_q <= blank_hour_d;
      blank_min_q  <= blank_min_d;
    end
  end

  assign run_en     = run_en_q;
  assign inc_hour   = inc_hour_q & en;
  assign inc_min    = inc_min_q & en;
  assign clr_sec    = clr_sec_q & en;
  assign blank_hour = blank_hour_q;
  assign blank_min  = blank_min_q;
  assign mode       = state_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with short debounce/repeat/timeout.
module tb_clock_set_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       tick_half = 1'b0;
  logic       run_en, inc_hour, inc_min, clr_sec, blank_hour, blank_min;
  logic [1:0] mode;

  int vectors = 0;
  int errors  = 0;

  int cyc = 0;
  int n_inc_hour = 0;
  int n_clr_sec = 0;
  int n_blank = 0;
  int inc_min_stamps[$];

  clock_set_controller #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (16),
    .REPEAT_PERIOD   (8),
    .TIMEOUT_HALF    (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .tick_half  (tick_half),
    .run_en     (run_en),
    .inc_hour   (inc_hour),
    .inc_min    (inc_min),
    .clr_sec    (clr_sec),
    .blank_hour (blank_hour),
    .blank_min  (blank_min),
    .mode       (mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (inc_hour === 1'b1) n_inc_hour++;
    if (clr_sec === 1'b1) n_clr_sec++;
    if (blank_hour === 1'b1 || blank_min === 1'b1) n_blank++;
    if (inc_min === 1'b1) inc_min_stamps.push_back(cyc);
  end

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold a button (0 = MODE, 1 = INC) for n cycles, release, let it settle.
  task automatic hold_btn(input bit which, input int n);
    if (which) btn_inc = 1'b1; else btn_mode = 1'b1;
    cycles(n);
    btn_inc  = 1'b0;
    btn_mode = 1'b0;
    cycles(12);
  endtask

  task automatic test_reset;
    int b_h, b_m, b_c, b_b;
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    b_h = n_inc_hour; b_m = inc_min_stamps.size(); b_c = n_clr_sec; b_b = n_blank;
    cycles(50);
    vectors++;
    if (run_en !== 1'b1) begin errors++; $display("FAIL reset_run_en: got %b want 1", run_en); end
    vectors++;
    if (mode !== 2'b00) begin errors++; $display("FAIL reset_mode: got %b want 00", mode); end
    vectors++;
    if ((n_inc_hour - b_h) + (inc_min_stamps.size() - b_m) + (n_clr_sec - b_c) !== 0) begin
      errors++; $display("FAIL reset_pulses: got %0d pulses want 0",
                         (n_inc_hour - b_h) + (inc_min_stamps.size() - b_m) + (n_clr_sec - b_c));
    end
    vectors++;
    if (n_blank - b_b !== 0) begin errors++; $display("FAIL reset_blank: got %0d blank cycles want 0", n_blank - b_b); end
  endtask

  task automatic test_glitch;
    btn_mode = 1'b1;
    cycles(3);
    btn_mode = 1'b0;
    cycles(20);
    vectors++;
    if (mode !== 2'b00) begin errors++; $display("FAIL glitch_mode: got %b want 00", mode); end
  endtask

  task automatic test_mode_enter;
    btn_mode = 1'b1;
    cycles(6);
    vectors++;
    if (mode !== 2'b00) begin errors++; $display("FAIL enter_early: got %b want 00 at edge 6", mode); end
    cycles(1);
    vectors++;
    if (mode !== 2'b01) begin errors++; $display("FAIL enter_mode: got %b want 01 at edge 7", mode); end
    vectors++;
    if (run_en !== 1'b0) begin errors++; $display("FAIL enter_run_en: got %b want 0", run_en); end
    cycles(13);
    btn_mode = 1'b0;
    cycles(12);
  endtask

  task automatic test_inc_hour;
    int b_h, b_m, b_c;
    b_h = n_inc_hour; b_m = inc_min_stamps.size(); b_c = n_clr_sec;
    hold_btn(1'b1, 8);
    hold_btn(1'b1, 8);
    hold_btn(1'b0, 8);
    vectors++;
    if (n_inc_hour - b_h !== 2) begin errors++; $display("FAIL inc_hour_count: got %0d want 2", n_inc_hour - b_h); end
    vectors++;
    if (inc_min_stamps.size() - b_m !== 0) begin errors++; $display("FAIL inc_hour_no_min: got %0d want 0", inc_min_stamps.size() - b_m); end
    vectors++;
    if (n_clr_sec - b_c !== 0) begin errors++; $display("FAIL inc_hour_no_clr: got %0d want 0", n_clr_sec - b_c); end
    vectors++;
    if (mode !== 2'b10) begin errors++; $display("FAIL to_set_min: got %b want 10", mode); end
  endtask

  task automatic test_inc_min_exit;
    int b_m, b_c;
    b_m = inc_min_stamps.size(); b_c = n_clr_sec;
    hold_btn(1'b1, 8);
    hold_btn(1'b0, 8);
    vectors++;
    if (inc_min_stamps.size() - b_m !== 1) begin errors++; $display("FAIL inc_min_count: got %0d want 1", inc_min_stamps.size() - b_m); end
    vectors++;
    if (mode !== 2'b00) begin errors++; $display("FAIL exit_mode: got %b want 00", mode); end
    vectors++;
    if (n_clr_sec - b_c !== 1) begin errors++; $display("FAIL exit_clr_sec: got %0d want 1", n_clr_sec - b_c); end
    vectors++;
    if (run_en !== 1'b1) begin errors++; $display("FAIL exit_run_en: got %b want 1", run_en); end
  endtask

  task automatic test_autorepeat;
    int base, e0;
    int exp_off[7] = '{7, 23, 31, 39, 47, 55, 63};
    hold_btn(1'b0, 8);
    hold_btn(1'b0, 8);
    vectors++;
    if (mode !== 2'b10) begin errors++; $display("FAIL rep_setup_mode: got %b want 10", mode); end
    base = inc_min_stamps.size();
    e0 = cyc;
    btn_inc = 1'b1;
    cycles(60);
    btn_inc = 1'b0;
    cycles(30);
    vectors++;
    if (inc_min_stamps.size() - base !== 7) begin
      errors++; $display("FAIL rep_count: got %0d want 7", inc_min_stamps.size() - base);
    end
    for (int i = 0; i < 7; i++) begin
      if (base + i < inc_min_stamps.size()) begin
        vectors++;
        if (inc_min_stamps[base + i] - e0 !== exp_off[i]) begin
          errors++; $display("FAIL rep_stamp%0d: got offset %0d want %0d", i, inc_min_stamps[base + i] - e0, exp_off[i]);
        end
      end
    end
    hold_btn(1'b0, 8);
  endtask

  task automatic test_timeout;
    int b_c;
    hold_btn(1'b0, 8);
    vectors++;
    if (mode !== 2'b01) begin errors++; $display("FAIL tmo_setup_mode: got %b want 01", mode); end
    b_c = n_clr_sec;
    for (int k = 1; k <= 6; k++) begin
      tick_half = 1'b1;
      cycles(1);
      tick_half = 1'b0;
      if (k < 6) begin
        vectors++;
        if (blank_hour !== 1'(k % 2)) begin errors++; $display("FAIL tmo_blink%0d: got %b want %0d", k, blank_hour, k % 2); end
        vectors++;
        if (mode !== 2'b01) begin errors++; $display("FAIL tmo_hold%0d: got %b want 01", k, mode); end
      end
      cycles(3);
    end
    vectors++;
    if (mode !== 2'b00) begin errors++; $display("FAIL tmo_exit_mode: got %b want 00", mode); end
    vectors++;
    if (blank_hour !== 1'b0) begin errors++; $display("FAIL tmo_exit_blank: got %b want 0", blank_hour); end
    vectors++;
    if (n_clr_sec - b_c !== 1) begin errors++; $display("FAIL tmo_clr_sec: got %0d want 1", n_clr_sec - b_c); end
    vectors++;
    if (run_en !== 1'b1) begin errors++; $display("FAIL tmo_run_en: got %b want 1", run_en); end
  endtask

  task automatic test_en_low;
    en = 1'b0;
    hold_btn(1'b0, 10);
    vectors++;
    if (mode !== 2'b00) begin errors++; $display("FAIL en_low_mode: got %b want 00", mode); end
    vectors++;
    if (run_en !== 1'b0) begin errors++; $display("FAIL en_low_run_en: got %b want 0", run_en); end
    en = 1'b1;
    cycles(10);
    vectors++;
    if (mode !== 2'b00) begin errors++; $display("FAIL en_restore_mode: got %b want 00", mode); end
    vectors++;
    if (run_en !== 1'b1) begin errors++; $display("FAIL en_restore_run_en: got %b want 1", run_en); end
  endtask

  task automatic test_simultaneous;
    int b_h, b_m;
    b_h = n_inc_hour; b_m = inc_min_stamps.size();
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    cycles(10);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cycles(12);
    vectors++;
    if (mode !== 2'b01) begin errors++; $display("FAIL simul_mode: got %b want 01", mode); end
    vectors++;
    if ((n_inc_hour - b_h) + (inc_min_stamps.size() - b_m) !== 0) begin
      errors++; $display("FAIL simul_no_inc: got %0d want 0", (n_inc_hour - b_h) + (inc_min_stamps.size() - b_m));
    end
  endtask

  task automatic test_reset_mid_set;
    hold_btn(1'b0, 8);
    vectors++;
    if (mode !== 2'b10) begin errors++; $display("FAIL midset_setup: got %b want 10", mode); end
    reset = 1'b1;
    cycles(1);
    vectors++;
    if (mode !== 2'b00) begin errors++; $display("FAIL midset_mode: got %b want 00", mode); end
    vectors++;
    if (run_en !== 1'b1) begin errors++; $display("FAIL midset_run_en: got %b want 1", run_en); end
    reset = 1'b0;
    cycles(5);
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_mode_enter();
    test_inc_hour();
    test_inc_min_exit();
    test_autorepeat();
    test_timeout();
    test_en_low();
    test_simultaneous();
    test_reset_mid_set();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
